// File: rtl/jtframe_dump_win.sv
// Frame-windowed dump controller: counts frames on falling vs edges and opens
// fixed-length capture windows by frame number and/or trigger, repeating with a gap.
//
// state    | meaning
// S_IDLE   | disarmed; outputs quiet, win_cnt held until next arm
// S_WAIT   | armed, waiting for the opening frame/trigger condition
// S_ACTIVE | window open, counting frames in len_cnt
// S_GAP    | between windows, counting frames in gap_cnt
// S_DONE   | REPEAT windows completed
module jtframe_dump_win #(
    parameter int unsigned FCW    = 32,
    parameter int unsigned CH     = 4,
    parameter int unsigned START  = 0,
    parameter int unsigned LENGTH = 1,
    parameter int unsigned GAP    = 0,
    parameter int unsigned REPEAT = 1,
    parameter int unsigned MODE   = 0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_vs,
    input  logic           i_trig,
    input  logic           i_arm,
    input  logic [CH-1:0]  i_ch_sel,
    output logic [FCW-1:0] o_frame_cnt,
    output logic           o_dump_on,
    output logic [CH-1:0]  o_dump_ch,
    output logic           o_start_pls,
    output logic           o_stop_pls,
    output logic [7:0]     o_win_cnt,
    output logic           o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACTIVE,
        S_GAP,
        S_DONE
    } state_t;

    state_t         r_state;
    logic           r_vs_l;
    logic           r_trig_l;
    logic [FCW-1:0] r_frame_cnt;
    logic           r_dump_on;
    logic [CH-1:0]  r_dump_ch;
    logic           r_start_pls;
    logic           r_stop_pls;
    logic [7:0]     r_win_cnt;
    logic           r_done;
    logic           r_trig_seen;
    logic [31:0]    r_len_cnt;
    logic [31:0]    r_gap_cnt;

    state_t         w_state_nxt;
    logic           w_dump_on_nxt;
    logic [CH-1:0]  w_dump_ch_nxt;
    logic           w_start_nxt;
    logic           w_stop_nxt;
    logic [7:0]     w_win_nxt;
    logic           w_done_nxt;
    logic           w_trig_seen_nxt;
    logic [31:0]    w_len_nxt;
    logic [31:0]    w_gap_nxt;

    logic           w_vs_fall;
    logic           w_trig_rise;
    logic           w_after_start;
    logic           w_trig_ok;
    logic           w_open_ok;
    logic [7:0]     w_win_inc;
    logic           w_len_last;
    logic           w_gap_last;
    logic           w_reach_repeat;

    assign w_vs_fall      = r_vs_l & ~i_vs;
    assign w_trig_rise    = ~r_trig_l & i_trig;
    assign w_after_start  = 64'(r_frame_cnt) >= 64'(START);
    assign w_trig_ok      = r_trig_seen | w_trig_rise;
    assign w_win_inc      = (r_win_cnt == 8'hff) ? 8'hff : r_win_cnt + 8'd1;
    assign w_len_last     = (LENGTH != 0) && (r_len_cnt == 32'(LENGTH - 1));
    assign w_gap_last     = (r_gap_cnt == 32'(GAP - 1));
    // REPEAT above 255 can never match the saturated counter, so done stays low
    assign w_reach_repeat = (REPEAT != 0) && (32'(w_win_inc) == REPEAT);

    always_comb begin
        if (MODE == 0)      w_open_ok = w_after_start;
        else if (MODE == 1) w_open_ok = w_trig_ok;
        else                w_open_ok = w_trig_ok & w_after_start;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_dump_on_nxt   = r_dump_on;
        w_dump_ch_nxt   = r_dump_ch;
        w_start_nxt     = 1'b0;
        w_stop_nxt      = 1'b0;
        w_win_nxt       = r_win_cnt;
        w_done_nxt      = r_done;
        w_trig_seen_nxt = r_trig_seen | w_trig_rise;
        w_len_nxt       = r_len_cnt;
        w_gap_nxt       = r_gap_cnt;
        if (!i_arm) begin
            w_state_nxt     = S_IDLE;
            w_stop_nxt      = r_dump_on;
            w_dump_on_nxt   = 1'b0;
            w_dump_ch_nxt   = '0;
            w_done_nxt      = 1'b0;
            w_trig_seen_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_win_nxt       = '0;
                    w_trig_seen_nxt = 1'b0;
                    w_done_nxt      = 1'b0;
                    w_state_nxt     = S_WAIT;
                end
                S_WAIT: begin
                    if (w_vs_fall && w_open_ok) begin
                        w_state_nxt   = S_ACTIVE;
                        w_dump_on_nxt = 1'b1;
                        w_dump_ch_nxt = i_ch_sel;
                        w_start_nxt   = 1'b1;
                        w_len_nxt     = '0;
                    end
                end
                S_ACTIVE: begin
                    if (w_vs_fall) begin
                        if (w_len_last) begin
                            w_stop_nxt = 1'b1;
                            w_win_nxt  = w_win_inc;
                            if (w_reach_repeat) begin
                                w_state_nxt   = S_DONE;
                                w_done_nxt    = 1'b1;
                                w_dump_on_nxt = 1'b0;
                                w_dump_ch_nxt = '0;
                            end else if (GAP == 0) begin
                                // back-to-back: close and reopen on the same frame edge
                                w_start_nxt   = 1'b1;
                                w_dump_ch_nxt = i_ch_sel;
                                w_len_nxt     = '0;
                            end else begin
                                w_state_nxt   = S_GAP;
                                w_dump_on_nxt = 1'b0;
                                w_dump_ch_nxt = '0;
                                w_gap_nxt     = '0;
                            end
                        end else begin
                            w_len_nxt = r_len_cnt + 32'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (w_vs_fall) begin
                        if (w_gap_last) begin
                            w_state_nxt   = S_ACTIVE;
                            w_dump_on_nxt = 1'b1;
                            w_dump_ch_nxt = i_ch_sel;
                            w_start_nxt   = 1'b1;
                            w_len_nxt     = '0;
                        end else begin
                            w_gap_nxt = r_gap_cnt + 32'd1;
                        end
                    end
                end
                S_DONE: begin
                    w_done_nxt    = 1'b1;
                    w_dump_on_nxt = 1'b0;
                    w_dump_ch_nxt = '0;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_vs_l      <= 1'b1;
            r_trig_l    <= 1'b1;
            r_frame_cnt <= '0;
            r_dump_on   <= 1'b0;
            r_dump_ch   <= '0;
            r_start_pls <= 1'b0;
            r_stop_pls  <= 1'b0;
            r_win_cnt   <= '0;
            r_done      <= 1'b0;
            r_trig_seen <= 1'b0;
            r_len_cnt   <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_vs_l      <= i_vs;
            r_trig_l    <= i_trig;
            if (w_vs_fall) r_frame_cnt <= r_frame_cnt + 1'b1;
            r_dump_on   <= w_dump_on_nxt;
            r_dump_ch   <= w_dump_ch_nxt;
            r_start_pls <= w_start_nxt;
            r_stop_pls  <= w_stop_nxt;
            r_win_cnt   <= w_win_nxt;
            r_done      <= w_done_nxt;
            r_trig_seen <= w_trig_seen_nxt;
            r_len_cnt   <= w_len_nxt;
            r_gap_cnt   <= w_gap_nxt;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
    assign o_dump_on   = r_dump_on;
    assign o_dump_ch   = r_dump_ch;
    assign o_start_pls = r_start_pls;
    assign o_stop_pls  = r_stop_pls;
    assign o_win_cnt   = r_win_cnt;
    assign o_done      = r_done;

endmodule

// File: tb/tb_jtframe_dump_win.sv
// Randomized bench for jtframe_dump_win: three parameterisations share one stimulus
// stream and are compared every cycle against a frame-arithmetic window model.
module tb_jtframe_dump_win;

    localparam int P_FCW   [3] = '{32, 32, 4};
    localparam int P_MODE  [3] = '{0, 1, 2};
    localparam int P_START [3] = '{3, 0, 10};
    localparam int P_LEN   [3] = '{2, 1, 3};
    localparam int P_GAP   [3] = '{0, 2, 1};
    localparam int P_REP   [3] = '{2, 3, 0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vs = 1'b1;
    logic       trig = 1'b0;
    logic       arm = 1'b1;
    logic [3:0] ch_sel = 4'd0;

    always #5 clk = ~clk;

    logic [31:0] fc_a, fc_b;
    logic [3:0]  fc_c;
    logic        on_w [3];
    logic [3:0]  ch_w [3];
    logic        st_w [3];
    logic        sp_w [3];
    logic [7:0]  wc_w [3];
    logic        dn_w [3];

    jtframe_dump_win #(.FCW(32), .CH(4), .START(3), .LENGTH(2), .GAP(0), .REPEAT(2), .MODE(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_vs(vs), .i_trig(trig), .i_arm(arm), .i_ch_sel(ch_sel),
        .o_frame_cnt(fc_a), .o_dump_on(on_w[0]), .o_dump_ch(ch_w[0]), .o_start_pls(st_w[0]),
        .o_stop_pls(sp_w[0]), .o_win_cnt(wc_w[0]), .o_done(dn_w[0]));

    jtframe_dump_win #(.FCW(32), .CH(4), .START(0), .LENGTH(1), .GAP(2), .REPEAT(3), .MODE(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_vs(vs), .i_trig(trig), .i_arm(arm), .i_ch_sel(ch_sel),
        .o_frame_cnt(fc_b), .o_dump_on(on_w[1]), .o_dump_ch(ch_w[1]), .o_start_pls(st_w[1]),
        .o_stop_pls(sp_w[1]), .o_win_cnt(wc_w[1]), .o_done(dn_w[1]));

    jtframe_dump_win #(.FCW(4), .CH(4), .START(10), .LENGTH(3), .GAP(1), .REPEAT(0), .MODE(2)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_vs(vs), .i_trig(trig), .i_arm(arm), .i_ch_sel(ch_sel),
        .o_frame_cnt(fc_c), .o_dump_on(on_w[2]), .o_dump_ch(ch_w[2]), .o_start_pls(st_w[2]),
        .o_stop_pls(sp_w[2]), .o_win_cnt(wc_w[2]), .o_done(dn_w[2]));

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Model: counts falls since arming, remembers the fall index of the first window,
    // then derives every later open/close from (LENGTH+GAP) period arithmetic.
    longint     fc_total;
    bit         prev_vs, prev_trig;
    int         m_ph   [3];
    int         m_o    [3];
    int         m_n    [3];
    bit         m_ts   [3];
    bit         m_on   [3];
    bit         m_start[3];
    bit         m_stop [3];
    bit         m_done [3];
    logic [3:0] m_ch   [3];
    int         m_win  [3];

    function automatic void model_reset();
        fc_total  = 0;
        prev_vs   = 1'b1;
        prev_trig = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_ph[i] = 0; m_o[i] = -1; m_n[i] = 0; m_ts[i] = 0; m_on[i] = 0;
            m_start[i] = 0; m_stop[i] = 0; m_done[i] = 0; m_ch[i] = 4'd0; m_win[i] = 0;
        end
    endfunction

    function automatic void win_eval(input int i, input int d);
        int per;
        int k;
        int r;
        bit live;
        per  = P_LEN[i] + P_GAP[i];
        k    = d / per;
        r    = d % per;
        live = (P_REP[i] == 0) || (k < P_REP[i]);
        if (d >= P_LEN[i] && ((d - P_LEN[i]) % per) == 0 &&
            (P_REP[i] == 0 || (d - P_LEN[i]) / per < P_REP[i])) begin
            m_stop[i] = 1'b1;
            if (m_win[i] < 255) m_win[i]++;
            if (P_REP[i] != 0 && m_win[i] == P_REP[i]) m_done[i] = 1'b1;
        end
        if (r == 0 && live) begin
            m_start[i] = 1'b1;
            m_ch[i]    = ch_sel;
        end
        m_on[i] = live && (r < P_LEN[i]);
        if (!m_on[i]) m_ch[i] = 4'd0;
    endfunction

    function automatic void model_step();
        bit     fall;
        bit     rise;
        bit     late;
        bit     ok;
        longint f;
        fall = prev_vs & ~vs;
        rise = ~prev_trig & trig;
        for (int i = 0; i < 3; i++) begin
            f = fc_total & ((64'd1 << P_FCW[i]) - 1);
            m_start[i] = 1'b0;
            m_stop[i]  = 1'b0;
            if (!arm) begin
                m_stop[i] = m_on[i];
                m_on[i] = 0; m_ch[i] = 4'd0; m_done[i] = 0; m_ts[i] = 0; m_ph[i] = 0;
            end else if (m_ph[i] == 0) begin
                m_ph[i] = 1; m_win[i] = 0; m_ts[i] = 0; m_o[i] = -1; m_n[i] = 0; m_done[i] = 0;
            end else begin
                m_ts[i] = m_ts[i] | rise;
                if (fall) begin
                    if (m_o[i] < 0) begin
                        late = (f >= longint'(P_START[i]));
                        case (P_MODE[i])
                            0:       ok = late;
                            1:       ok = m_ts[i];
                            default: ok = m_ts[i] && late;
                        endcase
                        if (ok) m_o[i] = m_n[i];
                    end
                    if (m_o[i] >= 0) win_eval(i, m_n[i] - m_o[i]);
                    m_n[i]++;
                end
            end
        end
        if (fall) fc_total++;
        prev_vs   = vs;
        prev_trig = trig;
    endfunction

    task automatic check_all();
        logic [31:0] fc_got [3];
        fc_got[0] = fc_a;
        fc_got[1] = fc_b;
        fc_got[2] = {28'd0, fc_c};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("outs%0d", i),
                {on_w[i], ch_w[i], st_w[i], sp_w[i], wc_w[i], dn_w[i]},
                {m_on[i], m_ch[i], m_start[i], m_stop[i], 8'(m_win[i]), m_done[i]});
            chk($sformatf("frame%0d", i), fc_got[i], fc_total & ((64'd1 << P_FCW[i]) - 1));
        end
    endtask

    int vs_cnt  = 4;
    int cyc_no  = 0;
    int trig_on = 0;

    task automatic run_cycles(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (vs_cnt == 0) begin
                vs     = 1'b0;
                vs_cnt = $urandom_range(3, 6);
            end else begin
                vs = 1'b1;
                vs_cnt--;
            end
            trig   = (cyc_no >= trig_on) && (cyc_no < trig_on + 2);
            ch_sel = 4'($urandom);
            @(posedge clk);
            model_step();
            #1;
            check_all();
            cyc_no++;
        end
    endtask

    task automatic wait_on(input int i);
        int k = 0;
        while (!m_on[i] && k < 80) begin
            run_cycles(1);
            k++;
        end
        chk($sformatf("reach_on%0d", i), {63'd0, on_w[i]}, 64'd1);
    endtask

    initial begin
        trig_on = $urandom_range(15, 40);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #1 rst_n = 1'b1;
        run_cycles(160);

        // drop arm while the unlimited-repeat instance has a window open
        wait_on(2);
        arm = 1'b0;
        run_cycles(3);
        arm = 1'b1;
        trig_on = cyc_no + $urandom_range(10, 30);
        run_cycles(120);

        // async reset in the middle of a window
        wait_on(2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #1 rst_n = 1'b1;
        trig_on = cyc_no + $urandom_range(5, 20);
        run_cycles(80);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
